// File: rtl/rosc_pkg.sv
// Shared definitions for the ring-oscillator odometer readers.
package rosc_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_WIN_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_SETTLE      = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        REPORT  = 2'd3
    } rosc_state_e;

    // The settle/window down-counter must hold both SETTLE-1 and WINDOW-1.
    function automatic int dcnt_width(input int win_w, input int settle);
        int settle_w;
        settle_w = $clog2(settle + 1);
        return (win_w > settle_w) ? win_w : settle_w;
    endfunction

endpackage

// File: rtl/rosc_count_reader_if.sv
// Start/done handshake between the odometer controller and a ROSC reader.
interface rosc_count_reader_if #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
);
    logic             start;
    logic             abort;
    logic [WIN_W-1:0] window;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             ovf;

    modport master (
        output start, abort, window,
        input  busy, done, count, ovf
    );

    modport slave (
        input  start, abort, window,
        output busy, done, count, ovf
    );
endinterface

// File: rtl/rosc_sync_edge.sv
// Synchronises an asynchronous oscillator output and flags its rising edges.
// The input must stay at each level for at least SYNC_STAGES+1 clocks,
// otherwise edges are silently lost. SYNC_STAGES must be at least 2.
module rosc_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw input through the synchroniser and keep the previous level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/rosc_count_reader.sv
// Enables one ROSC chain, counts its rising edges over a programmable window
// of clk cycles and reports the result through a start/done handshake.
module rosc_count_reader #(
    parameter int CNT_W       = rosc_pkg::DEF_CNT_W,
    parameter int WIN_W       = rosc_pkg::DEF_WIN_W,
    parameter int SYNC_STAGES = rosc_pkg::DEF_SYNC_STAGES,
    parameter int SETTLE      = rosc_pkg::DEF_SETTLE
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                rosc_en,
    input  logic                rosc_in,
    rosc_count_reader_if.slave  bus
);
    import rosc_pkg::*;

    localparam int DW = dcnt_width(WIN_W, SETTLE);

    localparam logic [1:0] ST_IDLE    = 2'(IDLE);
    localparam logic [1:0] ST_SETTLE  = 2'(rosc_pkg::SETTLE);
    localparam logic [1:0] ST_MEASURE = 2'(MEASURE);
    localparam logic [1:0] ST_REPORT  = 2'(REPORT);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state;
    logic [DW-1:0]    dcnt;
    logic [WIN_W-1:0] win_q;
    logic [CNT_W-1:0] ecnt;
    logic [CNT_W-1:0] ecnt_nxt;
    logic             eovf;
    logic             eovf_nxt;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic             edge_pulse;
    logic             active;

    rosc_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (rosc_in),
        .rise     (edge_pulse)
    );

    // Next value of the saturating edge counter; only MEASURE cycles count.
    always_comb begin
        ecnt_nxt = ecnt;
        eovf_nxt = eovf;
        if (state == ST_MEASURE && edge_pulse) begin
            if (ecnt == CNT_MAX) begin
                eovf_nxt = 1'b1;
            end else begin
                ecnt_nxt = ecnt + CNT_W'(1);
            end
        end
    end

    // Measurement sequencer: settle, measure, report, with abort back to idle.
    // COUNT/OVF are loaded on entry to REPORT so they are valid with DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            dcnt    <= '0;
            win_q   <= '0;
            ecnt    <= '0;
            eovf    <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        win_q <= bus.window;
                        ecnt  <= '0;
                        eovf  <= 1'b0;
                        dcnt  <= DW'(SETTLE - 1);
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (bus.abort) begin
                        state <= ST_IDLE;
                    end else if (dcnt == '0) begin
                        if (win_q == '0) begin
                            count_q <= ecnt;
                            ovf_q   <= eovf;
                            state   <= ST_REPORT;
                        end else begin
                            dcnt  <= DW'(win_q) - DW'(1);
                            state <= ST_MEASURE;
                        end
                    end else begin
                        dcnt <= dcnt - DW'(1);
                    end
                end
                ST_MEASURE: begin
                    ecnt <= ecnt_nxt;
                    eovf <= eovf_nxt;
                    if (bus.abort) begin
                        state <= ST_IDLE;
                    end else if (dcnt == '0) begin
                        count_q <= ecnt_nxt;
                        ovf_q   <= eovf_nxt;
                        state   <= ST_REPORT;
                    end else begin
                        dcnt <= dcnt - DW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign active    = (state == ST_SETTLE) || (state == ST_MEASURE);
    assign rosc_en   = active;
    assign bus.busy  = active;
    assign bus.done  = (state == ST_REPORT);
    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: doc/rosc_count_reader.md
# rosc_count_reader

Measurement front-end for the ring-oscillator odometer cells. It drives the select/enable input of one ROSC chain and synchronises the chain's free-running output into the system clock domain. It counts the oscillator's rising edges over a programmable window of CLK cycles and reports the count to the odometer controller through a start/done handshake.

## Interface

Parameters:
- CNT_W, 16, width of the edge counter and COUNT.
- WIN_W, 16, width of WINDOW.
- SYNC_STAGES, 2, synchroniser flops on ROSC_IN (minimum 2).
- SETTLE, 8, CLK cycles with ROSC_EN high before counting starts (minimum 1).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset; asynchronous assert, active-low.
- START  in  1  one-cycle request to begin a measurement; sampled only in IDLE.
- ABORT  in  1  cancels a measurement in progress; no DONE is produced.
- WINDOW  in  WIN_W  measurement length in CLK cycles; captured on an accepted START.
- ROSC_EN  out  1  oscillator enable/select; drives the ROSC chain input.
- ROSC_IN  in  1  oscillator output; asynchronous to CLK.
- BUSY  out  1  high from the cycle after an accepted START until DONE.
- DONE  out  1  one-cycle pulse; COUNT and OVF are valid from this cycle.
- COUNT  out  CNT_W  rising edges counted in the last completed window.
- OVF  out  1  counter saturated during the last window.

## Operation

- Reset values: ROSC_EN=0, BUSY=0, DONE=0, COUNT=0, OVF=0, state IDLE, synchroniser flops 0.
- States:
  - IDLE: ROSC_EN=0. START=1 captures WINDOW, clears the edge counter and moves to SETTLE.
  - SETTLE: ROSC_EN=1, BUSY=1. Lasts SETTLE cycles, then moves to MEASURE.
  - MEASURE: ROSC_EN=1, BUSY=1. Lasts the captured WINDOW cycles, then moves to REPORT.
  - REPORT: one cycle. DONE=1. COUNT and OVF are loaded from the edge counter. ROSC_EN=0, BUSY=0. Returns to IDLE.
- Edge detection:
  - ROSC_IN passes through SYNC_STAGES flops. One further flop holds the previous synchronised value.
  - An edge is the synchronised value being 1 while the previous value is 0.
  - The previous-value flop updates every cycle in every state, so a high level at MEASURE entry is not counted.
  - Edges are counted only in MEASURE cycles.
- Arithmetic:
  - The counter is CNT_W wide and saturates at 2^CNT_W-1.
  - An edge that arrives while the counter is saturated sets the internal overflow flag. The flag is copied to OVF in REPORT.
- WINDOW=0: MEASURE is skipped. SETTLE goes directly to REPORT, giving COUNT=0, OVF=0.
- START in any state other than IDLE is ignored. The WINDOW input is not re-sampled.
- ABORT in SETTLE or MEASURE:
  - Next cycle: IDLE with ROSC_EN=0 and BUSY=0.
  - No DONE. COUNT and OVF keep their previous values.
- ABORT in IDLE or REPORT has no effect. In REPORT the DONE pulse still occurs.
- ABORT and START together in IDLE: START wins.
- Reset asserted mid-measurement forces all outputs to their reset values immediately.
- Input frequency limit: ROSC_IN must have a high time and a low time each of at least SYNC_STAGES+1 CLK cycles. Faster inputs are under-counted; the block does not detect this.

## Timing

- START accepted at cycle t.
- ROSC_EN=1 and BUSY=1 from t+1.
- MEASURE occupies cycles t+1+SETTLE through t+SETTLE+WINDOW.
- DONE=1 at cycle t+1+SETTLE+WINDOW. ROSC_EN=0 in that same cycle.
- COUNT and OVF change only in the DONE cycle, or on reset.
- Edge-to-count latency: SYNC_STAGES+1 cycles.
  - An ROSC_IN edge counts only if its synchronised edge-detect pulse lands inside the MEASURE cycles.
  - Edges in the last SYNC_STAGES+1 cycles before REPORT are therefore lost.
  - Pulses from edges that occurred before MEASURE but land inside it are counted.
- A new START is accepted the cycle after DONE at the earliest.

## Structure

- Package rosc_pkg:
  - state enum {IDLE, SETTLE, MEASURE, REPORT};
  - default constants for CNT_W, WIN_W, SYNC_STAGES and SETTLE.
- Sub-module rosc_sync_edge: SYNC_STAGES synchroniser, previous-value flop and rising-edge pulse. Asynchronous active-low reset to 0. It is reused by the other odometer readers.
- Top level: FSM, settle/window down-counter (width max(WIN_W, clog2(SETTLE+1))), saturating edge counter, output registers.

## Test plan

- Basic count: SETTLE=8, WINDOW=60; bench drives ROSC_IN synchronously, toggling every 3 cycles (period 6). Expected: DONE at t+69, COUNT=10 ±1 (phase), OVF=0; ROSC_EN high exactly t+1..t+68.
- Saturation: CNT_W=4, WINDOW=200, period 6. Expected: COUNT=15, OVF=1.
- Zero window: WINDOW=0. Expected: DONE at t+9, COUNT=0, BUSY high t+1..t+8.
- Abort: ABORT asserted 20 cycles after START. Expected: next cycle ROSC_EN=0 and BUSY=0; no DONE; COUNT keeps its earlier value.
- Ignored START and level-at-entry:
  - Second START during MEASURE with a different WINDOW. Expected: no effect on timing or count.
  - ROSC_IN held high through SETTLE and MEASURE. Expected: COUNT=0.
- Reset mid-measurement: RST_N low during MEASURE. Expected: all outputs 0 asynchronously. A fresh START afterwards completes normally.
